// File: rtl/display_pkg.sv
// Shared types and constants for the 2-digit multiplexed 7-segment scanner.
// Segment patterns are {g,f,e,d,c,b,a}, active-low; digit enables are active-low.
package display_pkg;

  // Scan phases; the order is the order the FSM walks through them.
  typedef enum logic [1:0] {
    DIG0   = 2'd0,
    BLANK0 = 2'd1,
    DIG1   = 2'd2,
    BLANK1 = 2'd3
  } phase_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;

  localparam logic [1:0] AN_OFF  = 2'b11;
  localparam logic [1:0] AN_ONES = 2'b10;
  localparam logic [1:0] AN_TENS = 2'b01;

endpackage : display_pkg

// File: rtl/bcd_to_7seg.sv
// Combinational BCD nibble to active-low 7-segment pattern.
// Ports:
//   digit  - 4-bit BCD digit; 10..15 are treated as invalid
//   seg_c  - {g,f,e,d,c,b,a}, active-low; invalid digits show a dash
module bcd_to_7seg
  import display_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg_c
);

  always_comb begin
    seg_c = SEG_DASH;
    case (digit)
      4'd0:    seg_c = 7'h40;
      4'd1:    seg_c = 7'h79;
      4'd2:    seg_c = 7'h24;
      4'd3:    seg_c = 7'h30;
      4'd4:    seg_c = 7'h19;
      4'd5:    seg_c = 7'h12;
      4'd6:    seg_c = 7'h02;
      4'd7:    seg_c = 7'h78;
      4'd8:    seg_c = 7'h00;
      4'd9:    seg_c = 7'h10;
      default: seg_c = SEG_DASH;
    endcase
  end

endmodule : bcd_to_7seg

// File: rtl/bcd_display_scanner.sv
// Scans a packed 2-digit BCD value onto a multiplexed common-anode display.
// Each frame is DIG0 (ones), BLANK0, DIG1 (tens), BLANK1; new values are
// latched into the displayed register only on the BLANK1->DIG0 transition.
// Ports:
//   clk, rst_n   - clock, asynchronous active-low reset
//   bcd_in       - packed BCD, [7:4] tens, [3:0] ones
//   load         - capture bcd_in into the pending register
//   seg          - segments {g,f,e,d,c,b,a}, active-low, registered
//   an           - digit enables, active-low, an[0]=ones, an[1]=tens, registered
//   frame_start  - one-cycle pulse coinciding with the first DIG0 cycle
module bcd_display_scanner
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 50000,
  parameter int unsigned BLANK_CYCLES = 500,
  parameter bit          LZ_BLANK     = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] bcd_in,
  input  logic       load,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       frame_start
);

  localparam int unsigned MAX_LEN = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int unsigned CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [CNT_W-1:0] DIG_LAST   = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  phase_e           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [7:0]       pending, pending_nxt;
  logic [7:0]       display, display_nxt;
  logic [6:0]       seg_nxt;
  logic [1:0]       an_nxt;
  logic             frame_start_nxt;
  logic             phase_done;
  logic [3:0]       digit_sel;
  logic [6:0]       enc_seg;

  // Single shared encoder, fed with the digit of the phase being entered.
  bcd_to_7seg u_enc (
    .digit (digit_sel),
    .seg_c (enc_seg)
  );

  // State, counter, data and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= BLANK1;
      cnt         <= '0;
      pending     <= '0;
      display     <= '0;
      seg         <= SEG_BLANK;
      an          <= AN_OFF;
      frame_start <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      pending     <= pending_nxt;
      display     <= display_nxt;
      seg         <= seg_nxt;
      an          <= an_nxt;
      frame_start <= frame_start_nxt;
    end
  end

  // Next phase, counter, data transfer and next-cycle outputs.
  always_comb begin
    state_nxt       = state;
    cnt_nxt         = cnt + CNT_W'(1);
    pending_nxt     = load ? bcd_in : pending;
    display_nxt     = display;
    frame_start_nxt = 1'b0;
    seg_nxt         = SEG_BLANK;
    an_nxt          = AN_OFF;

    phase_done = ((state == DIG0) || (state == DIG1)) ? (cnt == DIG_LAST)
                                                       : (cnt == BLANK_LAST);

    if (phase_done) begin
      cnt_nxt = '0;
      case (state)
        DIG0:    state_nxt = BLANK0;
        BLANK0:  state_nxt = DIG1;
        DIG1:    state_nxt = BLANK1;
        BLANK1:  state_nxt = DIG0;
        default: state_nxt = BLANK1;
      endcase
    end

    // Frame boundary: show the value pending before this edge's load.
    if (phase_done && (state == BLANK1)) begin
      display_nxt     = pending;
      frame_start_nxt = 1'b1;
    end

    // Outputs are registered, so decode from the phase/value being entered.
    digit_sel = (state_nxt == DIG1) ? display_nxt[7:4] : display_nxt[3:0];

    case (state_nxt)
      DIG0: begin
        an_nxt  = AN_ONES;
        seg_nxt = enc_seg;
      end
      DIG1: begin
        if (!(LZ_BLANK && (display_nxt[7:4] == 4'd0))) begin
          an_nxt  = AN_TENS;
          seg_nxt = enc_seg;
        end
      end
      default: begin
        an_nxt  = AN_OFF;
        seg_nxt = SEG_BLANK;
      end
    endcase
  end

endmodule : bcd_display_scanner

// File: tb/tb_bcd_display_scanner.sv
// Bench for bcd_display_scanner with REFRESH_DIV=4, BLANK_CYCLES=2.
// Two instances share stimulus: one with leading-zero blanking, one without.
module tb_bcd_display_scanner;

  localparam int unsigned RD = 4;
  localparam int unsigned BC = 2;
  localparam int FRAME = 2 * (RD + BC);

  localparam logic [6:0] ENC_TAB [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F
  };

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] bcd_in = 8'h00;
  logic       load = 1'b0;
  logic [6:0] seg1, seg0;
  logic [1:0] an1, an0;
  logic       fs1, fs0;

  int         vectors = 0;
  int         miscompares = 0;

  // Reference model state: edges since reset release, pending and shown value.
  int         k = 0;
  logic [7:0] pend_m = 8'h00;
  logic [7:0] disp_m = 8'h00;

  always #5 clk = ~clk;

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b1)) u_lz (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .seg(seg1), .an(an1), .frame_start(fs1)
  );

  bcd_display_scanner #(.REFRESH_DIV(RD), .BLANK_CYCLES(BC), .LZ_BLANK(1'b0)) u_nolz (
    .clk(clk), .rst_n(rst_n), .bcd_in(bcd_in), .load(load),
    .seg(seg0), .an(an0), .frame_start(fs0)
  );

  // Position within the frame; -1 during the initial blank after reset.
  function automatic int cur_q();
    return (k < BC) ? -1 : (k - BC) % FRAME;
  endfunction

  // Expected {seg, an, frame_start} from the frame position and shown value.
  function automatic logic [9:0] model_out(input bit lz);
    int q;
    logic [6:0] s;
    logic [1:0] a;
    q = cur_q();
    s = 7'h7F;
    a = 2'b11;
    if (q >= 0 && q < RD) begin
      s = ENC_TAB[disp_m[3:0]];
      a = 2'b10;
    end else if (q >= RD + BC && q < 2 * RD + BC) begin
      if (!(lz && disp_m[7:4] == 4'd0)) begin
        s = ENC_TAB[disp_m[7:4]];
        a = 2'b01;
      end
    end
    return {s, a, (q == 0)};
  endfunction

  // One clock: drive inputs, advance the model at the edge, return at negedge.
  task automatic step(input logic ld, input logic [7:0] v);
    load   = ld;
    bcd_in = v;
    @(posedge clk);
    k = k + 1;
    if (cur_q() == 0) disp_m = pend_m;
    if (ld) pend_m = v;
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic model_reset();
    k = 0;
    pend_m = 8'h00;
    disp_m = 8'h00;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if ({seg1, an1, fs1} !== {7'h7F, 2'b11, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_lz got=%h/%b/%b want=7f/11/0", seg1, an1, fs1);
    end
    vectors++;
    if ({seg0, an0, fs0} !== {7'h7F, 2'b11, 1'b0}) begin
      miscompares++;
      $display("FAIL reset_nolz got=%h/%b/%b want=7f/11/0", seg0, an0, fs0);
    end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int last_fs;
    last_fs = -1;
    step(1'b1, 8'h47);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 8'h00);
      vectors++;
      if ({seg1, an1, fs1} !== model_out(1'b1)) begin
        miscompares++;
        $display("FAIL basic_lz k=%0d got=%h/%b/%b want=%h", k, seg1, an1, fs1, model_out(1'b1));
      end
      if (fs1) begin
        if (last_fs >= 0) begin
          vectors++;
          if (k - last_fs != FRAME) begin
            miscompares++;
            $display("FAIL frame_len got=%0d want=%0d", k - last_fs, FRAME);
          end
        end
        last_fs = k;
      end
      if (k == BC) begin
        vectors++;
        if ({seg1, an1} !== {7'h78, 2'b10}) begin
          miscompares++;
          $display("FAIL first_dig0 got=%h/%b want=78/10", seg1, an1);
        end
      end
    end
  endtask

  task automatic test_value(input logic [7:0] v, input string name);
    while (cur_q() != 4) step(1'b0, 8'h00);
    step(1'b1, v);
    for (int i = 0; i < 2 * FRAME; i++) begin
      step(1'b0, 8'h00);
      vectors++;
      if ({seg1, an1, fs1} !== model_out(1'b1)) begin
        miscompares++;
        $display("FAIL %s_lz k=%0d got=%h/%b/%b want=%h", name, k, seg1, an1, fs1, model_out(1'b1));
      end
      vectors++;
      if ({seg0, an0, fs0} !== model_out(1'b0)) begin
        miscompares++;
        $display("FAIL %s_nolz k=%0d got=%h/%b/%b want=%h", name, k, seg0, an0, fs0, model_out(1'b0));
      end
    end
  endtask

  task automatic test_tearing();
    logic [7:0] shown_before;
    while (cur_q() != RD + BC + 1) step(1'b0, 8'h00);
    shown_before = disp_m;
    step(1'b1, 8'h12);
    vectors++;
    if ({seg1, an1} !== model_out(1'b1) >> 1 || shown_before !== disp_m) begin
      miscompares++;
      $display("FAIL tear_midload got=%h/%b want=%h", seg1, an1, model_out(1'b1) >> 1);
    end
    while (cur_q() != FRAME - 1) step(1'b0, 8'h00);
    step(1'b1, 8'h99);
    vectors++;
    if ({seg1, an1, fs1} !== {7'h24, 2'b10, 1'b1}) begin
      miscompares++;
      $display("FAIL tear_frame12 got=%h/%b/%b want=24/10/1", seg1, an1, fs1);
    end
    for (int i = 0; i < FRAME; i++) begin
      step(1'b0, 8'h00);
      vectors++;
      if ({seg0, an0, fs0} !== model_out(1'b0)) begin
        miscompares++;
        $display("FAIL tear_nolz k=%0d got=%h/%b/%b want=%h", k, seg0, an0, fs0, model_out(1'b0));
      end
    end
    vectors++;
    if ({seg1, an1, fs1} !== {7'h10, 2'b10, 1'b1}) begin
      miscompares++;
      $display("FAIL tear_frame99 got=%h/%b/%b want=10/10/1", seg1, an1, fs1);
    end
  endtask

  task automatic test_reset_mid();
    step(1'b1, 8'h86);
    while (cur_q() != 1) step(1'b0, 8'h00);
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({seg0, an0, fs0} !== {7'h7F, 2'b11, 1'b0}) begin
      miscompares++;
      $display("FAIL async_reset got=%h/%b/%b want=7f/11/0", seg0, an0, fs0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FRAME + BC; i++) begin
      step(1'b0, 8'h00);
      vectors++;
      if ({seg0, an0, fs0} !== model_out(1'b0)) begin
        miscompares++;
        $display("FAIL rst_mid_nolz k=%0d got=%h/%b/%b want=%h", k, seg0, an0, fs0, model_out(1'b0));
      end
      vectors++;
      if ({seg1, an1, fs1} !== model_out(1'b1)) begin
        miscompares++;
        $display("FAIL rst_mid_lz k=%0d got=%h/%b/%b want=%h", k, seg1, an1, fs1, model_out(1'b1));
      end
      if (k == BC) begin
        vectors++;
        if ({seg0, an0} !== {7'h40, 2'b10}) begin
          miscompares++;
          $display("FAIL rst_first_lit got=%h/%b want=40/10", seg0, an0);
        end
      end
    end
  endtask

  task automatic test_random();
    int fs_count;
    logic ld;
    fs_count = 0;
    for (int i = 0; i < 100 * FRAME; i++) begin
      ld = ($urandom % 4) == 0;
      step(ld, 8'($urandom));
      if (fs1) fs_count++;
      vectors++;
      if (an1 === 2'b00 || an0 === 2'b00) begin
        miscompares++;
        $display("FAIL an_both_on k=%0d got=%b/%b", k, an1, an0);
      end
      vectors++;
      if ({seg1, an1, fs1} !== model_out(1'b1)) begin
        miscompares++;
        $display("FAIL rand_lz k=%0d got=%h/%b/%b want=%h", k, seg1, an1, fs1, model_out(1'b1));
      end
      vectors++;
      if ({seg0, an0, fs0} !== model_out(1'b0)) begin
        miscompares++;
        $display("FAIL rand_nolz k=%0d got=%h/%b/%b want=%h", k, seg0, an0, fs0, model_out(1'b0));
      end
    end
    vectors++;
    if (fs_count != 100) begin
      miscompares++;
      $display("FAIL frame_count got=%0d want=100", fs_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_value(8'h05, "lz05");
    test_value(8'h3A, "dash3a");
    test_value(8'hC0, "dashtens");
    test_tearing();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_bcd_display_scanner
